// File: rtl/tdc_sequencer_if.sv
// Control, event-counter and readout signals of the TDC measurement sequencer.
// result_min/result_max exist only when TDC_SEQ_MINMAX_EN is defined.
interface tdc_sequencer_if #(
    parameter int unsigned COUNTER_BITS = 8
);
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic [COUNTER_BITS-1:0] cnt_value;
    logic [COUNTER_BITS-1:0] result;
    logic                    result_valid;
    logic                    result_ready;
`ifdef TDC_SEQ_MINMAX_EN
    logic [COUNTER_BITS-1:0] result_min;
    logic [COUNTER_BITS-1:0] result_max;
`endif

    modport master (
        input  start, abort, cnt_value, result_ready,
`ifdef TDC_SEQ_MINMAX_EN
        output result_min, result_max,
`endif
        output busy, cnt_clear, cnt_en, result, result_valid
    );

    modport slave (
        output start, abort, cnt_value, result_ready,
`ifdef TDC_SEQ_MINMAX_EN
        input  result_min, result_max,
`endif
        input  busy, cnt_clear, cnt_en, result, result_valid
    );
endinterface

// File: rtl/tdc_sequencer.sv
// Runs 2^NUM_MEAS_LOG2 clear/window/settle/accumulate measurements and presents the
// truncated average on a valid/ready handshake. TDC_SEQ_MINMAX_EN adds min/max tracking.
module tdc_sequencer #(
    parameter int unsigned COUNTER_BITS  = 8,
    parameter int unsigned WINDOW_BITS   = 10,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_MEAS_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    tdc_sequencer_if.master  bus
);
    localparam int unsigned ACC_W = COUNTER_BITS + NUM_MEAS_LOG2;
    localparam int unsigned IDX_W = (NUM_MEAS_LOG2 > 0) ? NUM_MEAS_LOG2 : 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMR_W = (WINDOW_BITS > SET_W) ? WINDOW_BITS : SET_W;

    localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'((64'd1 << WINDOW_BITS) - 64'd1);
    localparam logic [TMR_W-1:0] SET_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] MEAS_LAST = IDX_W'((64'd1 << NUM_MEAS_LOG2) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WINDOW, S_SETTLE, S_ACCUM, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [COUNTER_BITS-1:0] result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    clear_q, clear_d;
    logic                    en_q, en_d;
    logic                    valid_q, valid_d;
    logic [COUNTER_BITS-1:0] ev_count;
    logic [ACC_W-1:0]        acc_sum;
`ifdef TDC_SEQ_MINMAX_EN
    logic [COUNTER_BITS-1:0] min_q, min_d, max_q, max_d;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef TDC_SEQ_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        // The counter runs down from zero, so the event count is its negation.
        ev_count = ~bus.cnt_value + 1'b1;
        acc_sum  = acc_q + ACC_W'(ev_count);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_CLEAR;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_WINDOW;
                tmr_d   = '0;
            end
            S_WINDOW: begin
                if (tmr_q == WIN_LAST) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == SET_LAST) state_d = S_ACCUM;
                else                   tmr_d   = tmr_q + 1'b1;
            end
            S_ACCUM: begin
                acc_d = acc_sum;
`ifdef TDC_SEQ_MINMAX_EN
                if (idx_q == '0 || ev_count < min_q) min_d = ev_count;
                if (idx_q == '0 || ev_count > max_q) max_d = ev_count;
`endif
                if (idx_q == MEAS_LAST) begin
                    state_d  = S_DONE;
                    result_d = COUNTER_BITS'(acc_sum >> NUM_MEAS_LOG2);
                end else begin
                    state_d = S_CLEAR;
                    idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything above, including a final ACCUM that would publish.
        if (state_q != S_IDLE && bus.abort) begin
            state_d  = S_IDLE;
            acc_d    = '0;
            result_d = result_q;
`ifdef TDC_SEQ_MINMAX_EN
            min_d    = min_q;
            max_d    = max_q;
`endif
        end

        busy_d  = (state_d != S_IDLE);
        clear_d = (state_d == S_CLEAR);
        en_d    = (state_d == S_WINDOW);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            clear_q  <= 1'b0;
            en_q     <= 1'b0;
            valid_q  <= 1'b0;
`ifdef TDC_SEQ_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            clear_q  <= clear_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
`ifdef TDC_SEQ_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    assign bus.busy         = busy_q;
    assign bus.cnt_clear    = clear_q;
    assign bus.cnt_en       = en_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
`ifdef TDC_SEQ_MINMAX_EN
    assign bus.result_min   = min_q;
    assign bus.result_max   = max_q;
`endif
endmodule

// File: tb/tb_tdc_sequencer.sv
// Scoreboard bench for tdc_sequencer: a behavioural down-counter feeds programmed event
// counts; expected averages are queued at start and checked at each result handshake.
module tb_tdc_sequencer;
    localparam int unsigned CB = 8;
    localparam int unsigned WB = 3;
    localparam int unsigned SC = 2;
    localparam int unsigned NL2 = 2;
    localparam int MEAS_CYC = 12;
    localparam int RUN_CYC  = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_sequencer_if #(.COUNTER_BITS(CB)) bus ();

    tdc_sequencer #(
        .COUNTER_BITS (CB),
        .WINDOW_BITS  (WB),
        .SETTLE_CYCLES(SC),
        .NUM_MEAS_LOG2(NL2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [CB-1:0] res;
        logic [CB-1:0] mn;
        logic [CB-1:0] mx;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [CB-1:0] pattern [4];
    logic [CB-1:0] ev_left;
    int clr_idx;

    // Event counter model: cleared by cnt_clear, counts down once per enabled cycle
    // until the programmed number of events for this measurement is used up.
    always @(posedge clk) begin
        if (rst) begin
            bus.cnt_value <= '0;
            ev_left       <= '0;
            clr_idx       <= 0;
        end else begin
            if (bus.start && !bus.abort && !bus.busy) clr_idx <= 0;
            if (bus.cnt_clear) begin
                bus.cnt_value <= '0;
                ev_left       <= pattern[clr_idx % 4];
                clr_idx       <= clr_idx + 1;
            end else if (bus.cnt_en && ev_left != '0) begin
                bus.cnt_value <= bus.cnt_value - 1'b1;
                ev_left       <= ev_left - 1'b1;
            end
        end
    end

    // Result scoreboard: one pop per accepted result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.result_valid && bus.result_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: result=%0d delivered with nothing expected", bus.result);
            end else begin
                e = exp_q.pop_front();
                if (bus.result !== e.res) begin
                    n_fail++;
                    $display("FAIL sb_result: got %0d expected %0d", bus.result, e.res);
                end
`ifdef TDC_SEQ_MINMAX_EN
                n_checks++;
                if (bus.result_min !== e.mn) begin
                    n_fail++;
                    $display("FAIL sb_min: got %0d expected %0d", bus.result_min, e.mn);
                end
                n_checks++;
                if (bus.result_max !== e.mx) begin
                    n_fail++;
                    $display("FAIL sb_max: got %0d expected %0d", bus.result_max, e.mx);
                end
`endif
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.busy, bus.cnt_clear, bus.cnt_en, bus.result_valid, bus.result} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d busy=%b clr=%b en=%b valid=%b result=%0d, all must be 0",
                         i, bus.busy, bus.cnt_clear, bus.cnt_en, bus.result_valid, bus.result);
            end
        end
    endtask

    task automatic test_single_value();
        int first_valid = -1;
        int errs = 0;
        int bad_j = -1;
        bit exp_clr, exp_en;
        pattern = '{8'd5, 8'd5, 8'd5, 8'd5};
        bus.result_ready = 1'b1;
        exp_q.push_back('{res: 8'd5, mn: 8'd5, mx: 8'd5});
        start_pulse();
        for (int j = 0; j < RUN_CYC + 2; j++) begin
            @(negedge clk);
            exp_clr = (j < RUN_CYC) && (j % MEAS_CYC == 0);
            exp_en  = (j < RUN_CYC) && (j % MEAS_CYC >= 1) && (j % MEAS_CYC <= 8);
            if (bus.cnt_clear !== exp_clr || bus.cnt_en !== exp_en) begin
                errs++;
                if (bad_j < 0) bad_j = j;
            end
            if (bus.result_valid && first_valid < 0) first_valid = j;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL strobe_timeline: %0d cycles wrong, first at cycle %0d, required 0 wrong", errs, bad_j);
        end
        n_checks++;
        if (first_valid != RUN_CYC) begin
            n_fail++;
            $display("FAIL valid_latency: first valid at cycle %0d, required %0d", first_valid, RUN_CYC);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_handshake: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_average();
        bit ok;
        pattern = '{8'd3, 8'd4, 8'd5, 8'd7};
        exp_q.push_back('{res: 8'd4, mn: 8'd3, mx: 8'd7});
        start_pulse();
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL avg_timeout: valid=0 required 1 within 200 cycles"); end
        wait_idle(10, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL avg_idle: busy=1 required 0"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int errs = 0;
        bus.result_ready = 1'b0;
        pattern = '{8'd6, 8'd6, 8'd6, 8'd6};
        exp_q.push_back('{res: 8'd6, mn: 8'd6, mx: 8'd6});
        start_pulse();
        repeat (4) @(negedge clk);
        @(posedge clk); #1 bus.start = 1'b1;
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: valid=0 required 1 within 200 cycles"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b1 || bus.result !== 8'd6 || bus.busy !== 1'b1 || bus.cnt_clear !== 1'b0)
                errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: %0d unstable cycles in DONE, required 0", errs);
        end
        exp_q.push_back('{res: 8'd6, mn: 8'd6, mx: 8'd6});
        @(posedge clk); #1 bus.result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 8'd6) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b valid=%b result=%0d, required 0 0 6",
                     bus.busy, bus.result_valid, bus.result);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cnt_clear !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: clr=%b busy=%b, required 1 1", bus.cnt_clear, bus.busy);
        end
        @(posedge clk); #1 bus.start = 1'b0;
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: valid=0 required 1"); end
        wait_idle(10, ok);
    endtask

    task automatic test_abort();
        bit ok;
        int vcount = 0;
        bus.result_ready = 1'b1;
        pattern = '{8'd7, 8'd7, 8'd7, 8'd7};
        start_pulse();
        repeat (16) @(negedge clk);
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.cnt_en !== 1'b0 || bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b en=%b valid=%b, required 0 0 0",
                     bus.busy, bus.cnt_en, bus.result_valid);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.result_valid || bus.busy) vcount++;
        end
        n_checks++;
        if (vcount != 0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: %0d active cycles after abort, required 0", vcount);
        end
        pattern = '{8'd2, 8'd2, 8'd2, 8'd2};
        exp_q.push_back('{res: 8'd2, mn: 8'd2, mx: 8'd2});
        start_pulse();
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_rerun_timeout: valid=0 required 1"); end
        wait_idle(10, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        pattern = '{8'd7, 8'd7, 8'd7, 8'd7};
        start_pulse();
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.cnt_clear, bus.cnt_en, bus.result_valid, bus.result} !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b clr=%b en=%b valid=%b result=%0d, all must be 0",
                     bus.busy, bus.cnt_clear, bus.cnt_en, bus.result_valid, bus.result);
        end
`ifdef TDC_SEQ_MINMAX_EN
        n_checks++;
        if (bus.result_min !== '0 || bus.result_max !== '0) begin
            n_fail++;
            $display("FAIL midreset_minmax: min=%0d max=%0d, required 0 0", bus.result_min, bus.result_max);
        end
`endif
        pattern = '{8'd0, 8'd0, 8'd0, 8'd0};
        exp_q.push_back('{res: 8'd0, mn: 8'd0, mx: 8'd0});
        start_pulse();
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midreset_rerun_timeout: valid=0 required 1"); end
        wait_idle(10, ok);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;
        pattern          = '{8'd0, 8'd0, 8'd0, 8'd0};
        test_reset();
        test_single_value();
        test_average();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected results never delivered, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
